// File: rtl/cp0_unit.sv
// MIPS-style coprocessor 0: SR, Cause, EPC and PRId with interrupt/exception request logic.
// Req is combinational; all register updates happen on the rising edge of clk.
module cp0_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_5A5A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] CP0Out,
  output logic [31:0] EPCOut,
  output logic        Req
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic [31:0] w_epc_next;

  assign w_int_req = r_ie & ~r_exl & (|(HWInt & r_im));
  assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_exl;
  assign Req       = w_int_req | w_exc_req;

  // A delay-slot instruction restarts at its branch; wraps mod 2^32.
  assign w_epc_next = (BDIn ? (VPC - 32'd4) : VPC) & 32'hFFFF_FFFC;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; later assignments in the block override earlier ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= '0;
      r_exc_code <= '0;
      r_epc      <= '0;
    end else begin
      r_ip <= HWInt;
      if (Req) begin
        // The faulting instruction is flushed, so any mtc0/eret it carries is dropped.
        r_exl      <= 1'b1;
        r_bd       <= BDIn;
        r_epc      <= w_epc_next;
        r_exc_code <= w_int_req ? 5'd0 : ExcCodeIn;
      end else begin
        if (en && (CP0Add == ADDR_SR)) begin
          r_im  <= CP0In[15:10];
          r_exl <= CP0In[1];
          r_ie  <= CP0In[0];
        end
        if (en && (CP0Add == ADDR_EPC)) begin
          r_epc <= CP0In & 32'hFFFF_FFFC;
        end
        if (EXLClr) begin
          r_exl <= 1'b0;
        end
      end
    end
  end

  // NOTE: the read mux assigns a default before the case so no latch is inferred.
  always_comb begin
    CP0Out = 32'h0;
    case (CP0Add)
      ADDR_SR:    CP0Out = {16'h0, r_im, 8'h0, r_exl, r_ie};
      ADDR_CAUSE: CP0Out = {r_bd, 15'h0, r_ip, 3'b000, r_exc_code, 2'b00};
      ADDR_EPC:   CP0Out = r_epc;
      ADDR_PRID:  CP0Out = PRID_VALUE;
      default:    CP0Out = 32'h0;
    endcase
  end

  assign EPCOut = r_epc;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: linear stimulus with hand-computed expectations,
// each compared by an immediate assertion.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] CP0Out;
  logic [31:0] EPCOut;
  logic        Req;

  int checks = 0;
  int errors = 0;

  cp0_unit dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .CP0Add    (CP0Add),
    .CP0In     (CP0In),
    .VPC       (VPC),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .CP0Out    (CP0Out),
    .EPCOut    (EPCOut),
    .Req       (Req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string tag);
    CP0Add = addr;
    #1;
    check(tag, CP0Out, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; CP0Add = 5'd0; CP0In = 32'h0; VPC = 32'h0;
    BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    #1;
    check("rst_req", {31'h0, Req}, 32'h0);
    check("rst_epcout", EPCOut, 32'h0);
    rd(5'd12, 32'h0, "rst_sr");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epc");
    rd(5'd15, 32'h0000_5A5A, "rst_prid");

    @(negedge clk);
    reset = 1'b0;

    // mtc0 SR = 0x401; the same-cycle read still shows the old value
    CP0Add = 5'd12; en = 1'b1; CP0In = 32'h0000_0401;
    #1;
    check("sr_no_bypass", CP0Out, 32'h0);
    check("sr_wr_req", {31'h0, Req}, 32'h0);
    tick();
    en = 1'b0;
    rd(5'd12, 32'h0000_0401, "sr_written");

    // interrupt on HWInt[0]
    HWInt = 6'b000001; VPC = 32'h0000_1000;
    #1;
    check("int_req", {31'h0, Req}, 32'h1);
    tick();
    rd(5'd12, 32'h0000_0403, "int_sr");
    rd(5'd13, 32'h0000_0400, "int_cause");
    rd(5'd14, 32'h0000_1000, "int_epc");
    check("int_epcout", EPCOut, 32'h0000_1000);
    check("int_masked", {31'h0, Req}, 32'h0);

    // EXL=1 masks exception and interrupt; only IP follows HWInt
    ExcCodeIn = 5'd10; HWInt = 6'b000011; VPC = 32'h0000_2000;
    #1;
    check("exl_mask_req", {31'h0, Req}, 32'h0);
    tick();
    rd(5'd12, 32'h0000_0403, "exl_mask_sr");
    rd(5'd13, 32'h0000_0C00, "exl_mask_cause");
    rd(5'd14, 32'h0000_1000, "exl_mask_epc");

    // eret with a pending enabled interrupt
    ExcCodeIn = 5'd0; HWInt = 6'b000001; EXLClr = 1'b1;
    #1;
    check("eret_req", {31'h0, Req}, 32'h0);
    tick();
    EXLClr = 1'b0;
    rd(5'd12, 32'h0000_0401, "eret_sr");
    check("eret_pending_req", {31'h0, Req}, 32'h1);
    tick();
    rd(5'd12, 32'h0000_0403, "reint_sr");
    rd(5'd14, 32'h0000_2000, "reint_epc");

    // clear SR so exceptions are accepted again
    HWInt = 6'd0; CP0Add = 5'd12; en = 1'b1; CP0In = 32'h0;
    tick();
    en = 1'b0;
    rd(5'd12, 32'h0, "sr_clear");
    rd(5'd13, 32'h0, "cause_clear");

    // exception in a delay slot
    ExcCodeIn = 5'd12; VPC = 32'h0000_3008; BDIn = 1'b1;
    #1;
    check("exc_bd_req", {31'h0, Req}, 32'h1);
    tick();
    ExcCodeIn = 5'd0; BDIn = 1'b0;
    rd(5'd13, 32'h8000_0030, "exc_bd_cause");
    rd(5'd14, 32'h0000_3004, "exc_bd_epc");
    rd(5'd12, 32'h0000_0002, "exc_bd_sr");

    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    rd(5'd12, 32'h0, "eret2_sr");

    // mtc0 EPC in the same cycle as an exception is dropped
    CP0Add = 5'd14; en = 1'b1; CP0In = 32'h0000_300B; ExcCodeIn = 5'd4; VPC = 32'h0000_4000;
    #1;
    check("drop_req", {31'h0, Req}, 32'h1);
    tick();
    en = 1'b0; ExcCodeIn = 5'd0;
    rd(5'd14, 32'h0000_4000, "drop_epc");
    rd(5'd13, 32'h0000_0010, "drop_cause");
    rd(5'd12, 32'h0000_0002, "drop_sr");

    // eret together with mtc0 EPC: write lands, low bits cleared
    EXLClr = 1'b1; en = 1'b1; CP0Add = 5'd14; CP0In = 32'h0000_300B;
    #1;
    check("eret_epcwr_req", {31'h0, Req}, 32'h0);
    tick();
    EXLClr = 1'b0; en = 1'b0;
    check("epc_written", EPCOut, 32'h0000_3008);
    rd(5'd12, 32'h0, "eret3_sr");

    // writes to Cause and PRId are ignored; unmapped reads are zero
    en = 1'b1; CP0Add = 5'd13; CP0In = 32'hFFFF_FFFF;
    tick();
    CP0Add = 5'd15;
    tick();
    en = 1'b0;
    rd(5'd13, 32'h0000_0010, "cause_ro");
    rd(5'd15, 32'h0000_5A5A, "prid_ro");
    rd(5'd7, 32'h0, "unmapped");

    // EPC wrap: VPC=0 in a delay slot
    VPC = 32'h0; BDIn = 1'b1; ExcCodeIn = 5'd1;
    #1;
    check("wrap_req", {31'h0, Req}, 32'h1);
    tick();
    ExcCodeIn = 5'd0; BDIn = 1'b0;
    rd(5'd14, 32'hFFFF_FFFC, "wrap_epc");
    rd(5'd13, 32'h8000_0004, "wrap_cause");

    // mtc0 SR with EXL=1 plus eret: mtc0 value, then EXL cleared
    en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0403; EXLClr = 1'b1;
    tick();
    en = 1'b0; EXLClr = 1'b0;
    rd(5'd12, 32'h0000_0401, "sr_eret_combo");

    // interrupt wins over a simultaneous exception code
    HWInt = 6'b000001; ExcCodeIn = 5'd5; VPC = 32'h0000_5000;
    #1;
    check("prio_req", {31'h0, Req}, 32'h1);
    tick();
    ExcCodeIn = 5'd0;
    rd(5'd13, 32'h0000_0400, "prio_cause");
    rd(5'd14, 32'h0000_5000, "prio_epc");
    rd(5'd12, 32'h0000_0403, "prio_sr");

    // asynchronous reset between edges while EXL=1
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_req", {31'h0, Req}, 32'h0);
    check("async_epcout", EPCOut, 32'h0);
    rd(5'd12, 32'h0, "async_sr");
    rd(5'd13, 32'h0, "async_cause");
    rd(5'd14, 32'h0, "async_epc");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_req", {31'h0, Req}, 32'h0);
    tick();
    rd(5'd13, 32'h0000_0400, "post_rst_ip");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL provide parameter PRID_VALUE, default 32'h0000_5A5A, value returned on reads of register 15.
REQ-002 SHALL provide port clk input 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset input 1: asynchronous, active-high; clears state immediately, independent of clk.
REQ-004 SHALL provide port en input 1: mtc0 write strobe from the control unit.
REQ-005 SHALL provide port CP0Add input 5: register number for mtc0 writes and mfc0 reads.
REQ-006 SHALL provide port CP0In input 32: mtc0 write data.
REQ-007 SHALL provide port VPC input 32: PC of the instruction in the exception stage.
REQ-008 SHALL provide port BDIn input 1: that instruction sits in a branch delay slot.
REQ-009 SHALL provide port ExcCodeIn input 5: exception code from the control unit; 0 = none.
REQ-010 SHALL provide port HWInt input 6: external interrupt lines, level-sensitive.
REQ-011 SHALL provide port EXLClr input 1: eret strobe.
REQ-012 SHALL provide port CP0Out output 32: mfc0 read data.
REQ-013 SHALL provide port EPCOut output 32: current EPC, the eret target.
REQ-014 SHALL provide port Req output 1: take exception/interrupt this cycle; drives NPCOp = handler.

Function
REQ-015 SHALL hold SR (reg 12): IM = bits 15:10, EXL = bit 1, IE = bit 0; all other bits read 0.
REQ-016 SHALL hold Cause (reg 13): BD = bit 31, IP = bits 15:10, ExcCode = bits 6:2; all other bits read 0.
REQ-017 SHALL hold EPC (reg 14) as 32 bits with bits 1:0 forced 0; reg 15 reads PRID_VALUE; any other address reads 32'h0.
REQ-018 SHALL compute IntReq = IE & !EXL & |(HWInt & IM) combinationally.
REQ-019 SHALL compute ExcReq = (ExcCodeIn != 0) & !EXL combinationally.
REQ-020 SHALL drive Req = IntReq | ExcReq with zero-cycle latency, from current register state and inputs only.
REQ-021 SHALL, on a clk edge with Req=1, set EXL=1, BD=BDIn, and EPC = (BDIn ? VPC-4 : VPC) with bits 1:0 cleared.
REQ-022 SHALL give interrupts priority: ExcCode=0 when IntReq=1, else ExcCode=ExcCodeIn.
REQ-023 SHALL load Cause.IP from HWInt on every clk edge, regardless of Req, en or EXL.
REQ-024 SHALL, on en=1 with Req=0, write CP0In to the addressed register: reg 12 writes IM/EXL/IE; reg 14 writes EPC (bits 1:0 cleared); regs 13, 15 and others ignore the write.
REQ-025 SHALL discard an mtc0 write in any cycle with Req=1, because the instruction is being flushed.
REQ-026 SHALL clear EXL on EXLClr=1 when Req=0; EXLClr and en to SR in the same cycle resolve as the mtc0 value, then EXL cleared.
REQ-027 SHALL keep Req=0 while EXL=1, so nested exceptions and interrupts are masked until eret.
REQ-028 SHALL drive CP0Out combinationally from CP0Add and current register contents; a same-cycle write is not bypassed.
REQ-029 SHALL drive EPCOut combinationally from the EPC register.
REQ-030 SHALL treat EPC address arithmetic as mod 2^32; VPC=0 with BDIn=1 yields EPC=32'hFFFF_FFFC.

Reset
REQ-031 SHALL, while reset=1, hold SR, Cause and EPC at 32'h0, so Req=0, CP0Out reads 0 (PRId excepted) and EPCOut=0.
REQ-032 SHALL apply reset asynchronously and take priority over Req, en and EXLClr; the first update after deassertion is the next clk rising edge.

Verification
REQ-033 SHALL cover: reset; mtc0 SR=32'h0000_0401; HWInt=6'b000001 -> Req=1 same cycle; next edge EXL=1, ExcCode=0, IP=1, EPC=VPC.
REQ-034 SHALL cover: ExcCodeIn=5'd12, VPC=32'h0000_3008, BDIn=1, EXL=0 -> Req=1; Cause=32'h8000_0030, EPC=32'h0000_3004.
REQ-035 SHALL cover: EXL=1 with ExcCodeIn=5'd10 and HWInt enabled -> Req=0; no register change except IP.
REQ-036 SHALL cover: en=1, CP0Add=14, CP0In=32'h0000_300B, with ExcCodeIn=5'd4 in the same cycle -> write dropped; EPC=VPC.
REQ-037 SHALL cover: EXLClr=1 with EXL=1 -> next edge EXL=0; a pending enabled HWInt then raises Req in the following cycle.
REQ-038 SHALL cover: reset asserted mid-cycle between edges while EXL=1 -> SR, Cause and EPC read 0 immediately, and Req=0.
